// File: rtl/mips_exc_ctrl_if.sv
// Commit-stage / CP0 signal bundle for the exception sequencer.
// The i_/o_ prefixes are from the controller's point of view.
interface mips_exc_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              i_ev_valid;
  logic [ADDR_W-1:0] i_ev_pc;
  logic              i_ev_bd;
  logic              i_ev_adel;
  logic              i_ev_ri;
  logic              i_ev_syscall;
  logic              i_ev_break;
  logic              i_ev_ovf;
  logic              i_ev_ades;
  logic              i_ev_eret;
  logic              i_exc_occur;
  logic [ADDR_W-1:0] i_exc_npc;

  logic              o_exc_set;
  logic [3:0]        o_exc_code;
  logic [ADDR_W-1:0] o_exc_epc;
  logic              o_exc_bd;
  logic              o_exc_ack;
  logic              o_exc_clr;
  logic              o_stall;
  logic              o_flush;
  logic              o_redirect;
  logic [ADDR_W-1:0] o_redirect_pc;

  modport master (
    output i_ev_valid, i_ev_pc, i_ev_bd, i_ev_adel, i_ev_ri, i_ev_syscall,
           i_ev_break, i_ev_ovf, i_ev_ades, i_ev_eret, i_exc_occur, i_exc_npc,
    input  o_exc_set, o_exc_code, o_exc_epc, o_exc_bd, o_exc_ack, o_exc_clr,
           o_stall, o_flush, o_redirect, o_redirect_pc
  );

  modport slave (
    input  i_ev_valid, i_ev_pc, i_ev_bd, i_ev_adel, i_ev_ri, i_ev_syscall,
           i_ev_break, i_ev_ovf, i_ev_ades, i_ev_eret, i_exc_occur, i_exc_npc,
    output o_exc_set, o_exc_code, o_exc_epc, o_exc_bd, o_exc_ack, o_exc_clr,
           o_stall, o_flush, o_redirect, o_redirect_pc
  );
endinterface

// File: rtl/mips_exc_ctrl.sv
// Exception sequencer between the commit stage and CP0: runs the SET/WAIT/
// FLUSH/ACK handshake for exceptions and interrupts, and CLR/RDR for ERET.
module mips_exc_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 3
) (
  input logic           clk,
  input logic           rst,
  mips_exc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SET, S_WAIT, S_FLUSH, S_ACK, S_CLR, S_RDR
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_exc_set;
  logic [3:0]        r_exc_code;
  logic [ADDR_W-1:0] r_exc_epc;
  logic              r_exc_bd;
  logic              r_exc_ack;
  logic              r_exc_clr;
  logic              r_stall;
  logic              r_flush;
  logic              r_redirect;
  logic [ADDR_W-1:0] r_redirect_pc;

  logic              w_exc_any;
  logic [3:0]        w_code;
  logic [ADDR_W-1:0] w_epc;

  assign w_exc_any = bus.i_ev_adel | bus.i_ev_ri | bus.i_ev_syscall |
                     bus.i_ev_break | bus.i_ev_ovf | bus.i_ev_ades;

  // A delay-slot instruction restarts at its branch, one word earlier.
  assign w_epc = bus.i_ev_bd ? (bus.i_ev_pc - ADDR_W'(4)) : bus.i_ev_pc;

  always_comb begin
    w_code = 4'd0;
    if (bus.i_ev_adel)         w_code = 4'd4;
    else if (bus.i_ev_ri)      w_code = 4'd10;
    else if (bus.i_ev_syscall) w_code = 4'd8;
    else if (bus.i_ev_break)   w_code = 4'd9;
    else if (bus.i_ev_ovf)     w_code = 4'd12;
    else if (bus.i_ev_ades)    w_code = 4'd5;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_exc_set     <= 1'b0;
      r_exc_code    <= 4'd0;
      r_exc_epc     <= '0;
      r_exc_bd      <= 1'b0;
      r_exc_ack     <= 1'b0;
      r_exc_clr     <= 1'b0;
      r_stall       <= 1'b0;
      r_flush       <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_exc_set  <= 1'b0;
      r_exc_ack  <= 1'b0;
      r_exc_clr  <= 1'b0;
      r_redirect <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_ev_valid && w_exc_any) begin
            r_state    <= S_SET;
            r_exc_set  <= 1'b1;
            r_stall    <= 1'b1;
            r_exc_code <= w_code;
            r_exc_epc  <= w_epc;
            r_exc_bd   <= bus.i_ev_bd;
          end else if (bus.i_ev_valid && bus.i_ev_eret) begin
            r_state   <= S_CLR;
            r_exc_clr <= 1'b1;
            r_stall   <= 1'b1;
          end else if (bus.i_ev_valid && bus.i_exc_occur) begin
            // Interrupt: CP0 already has it pending, so skip SET/WAIT.
            r_state    <= S_FLUSH;
            r_stall    <= 1'b1;
            r_flush    <= 1'b1;
            r_cnt      <= FLUSH_INIT;
            r_exc_code <= 4'd0;
            r_exc_epc  <= w_epc;
            r_exc_bd   <= bus.i_ev_bd;
          end
        end
        S_SET: r_state <= S_WAIT;
        S_WAIT: begin
          if (bus.i_exc_occur) begin
            r_state <= S_FLUSH;
            r_flush <= 1'b1;
            r_cnt   <= FLUSH_INIT;
          end
        end
        S_FLUSH: begin
          if (r_cnt == 4'd0) begin
            r_state       <= S_ACK;
            r_flush       <= 1'b0;
            r_exc_ack     <= 1'b1;
            r_redirect    <= 1'b1;
            r_redirect_pc <= bus.i_exc_npc;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_stall <= 1'b0;
        end
        S_CLR: begin
          r_state       <= S_RDR;
          r_redirect    <= 1'b1;
          r_redirect_pc <= bus.i_exc_npc;
          r_flush       <= 1'b1;
        end
        S_RDR: begin
          r_state <= S_IDLE;
          r_flush <= 1'b0;
          r_stall <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_flush <= 1'b0;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_exc_set     = r_exc_set;
  assign bus.o_exc_code    = r_exc_code;
  assign bus.o_exc_epc     = r_exc_epc;
  assign bus.o_exc_bd      = r_exc_bd;
  assign bus.o_exc_ack     = r_exc_ack;
  assign bus.o_exc_clr     = r_exc_clr;
  assign bus.o_stall       = r_stall;
  assign bus.o_flush       = r_flush;
  assign bus.o_redirect    = r_redirect;
  assign bus.o_redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_mips_exc_ctrl.sv
// Scoreboard bench for mips_exc_ctrl: stimulus queues per-cycle expected
// outputs, a negedge monitor compares every non-idle cycle against them.
module tb_mips_exc_ctrl;

  localparam int FC = 3;

  typedef struct packed {
    logic        set;
    logic [3:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic        ack;
    logic        clr;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] rpc;
  } outVec_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   zeroChk = 0;
  bit   idleChk = 0;
  bit   endChk = 0;

  outVec_t expQ[$];
  string   nameQ[$];
  int      cycQ[$];
  bit      chkQ[$];

  mips_exc_ctrl_if #(.ADDR_W(32)) bus ();

  mips_exc_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(FC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic outVec_t sampleOut();
    outVec_t v;
    v.set      = bus.o_exc_set;
    v.code     = bus.o_exc_code;
    v.epc      = bus.o_exc_epc;
    v.bd       = bus.o_exc_bd;
    v.ack      = bus.o_exc_ack;
    v.clr      = bus.o_exc_clr;
    v.stall    = bus.o_stall;
    v.flush    = bus.o_flush;
    v.redirect = bus.o_redirect;
    v.rpc      = bus.o_redirect_pc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int expCyc, input outVec_t e, input bit chkLatch);
    outVec_t a;
    a = sampleOut();
    if (!chkLatch) begin
      a.code = e.code;
      a.epc  = e.epc;
      a.bd   = e.bd;
    end
    if (!e.redirect) a.rpc = e.rpc;
    checks++;
    if (a !== e || cyc != expCyc) begin
      errors++;
      $display("[TB] FAIL %s: got cyc=%0d out=%h, expected cyc=%0d out=%h", name, cyc, a, expCyc, e);
    end
  endtask

  always @(negedge clk) begin
    outVec_t a;
    a = sampleOut();
    if (zeroChk) begin
      checks++;
      if (a !== '0) begin
        errors++;
        $display("[TB] FAIL reset_zero: got %h, expected all zero", a);
      end
    end else if (idleChk) begin
      checks++;
      if (a.stall !== 1'b0 || a.set !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_no_stall: got stall=%b set=%b, expected 0/0", a.stall, a.set);
      end
    end else if (a.stall || a.set || a.ack || a.clr || a.flush || a.redirect) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_activity: got out=%h at cyc=%0d, expected idle", a, cyc);
      end else begin
        checkOutput(nameQ.pop_front(), cycQ.pop_front(), expQ.pop_front(), chkQ.pop_front());
      end
    end
    if (endChk) begin
      checks++;
      if (expQ.size() != 0) begin
        errors++;
        $display("[TB] FAIL leftover_expectations: got %0d pending, expected 0", expQ.size());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input string name, input int expCyc, input outVec_t v, input bit chkLatch);
    expQ.push_back(v);
    nameQ.push_back(name);
    cycQ.push_back(expCyc);
    chkQ.push_back(chkLatch);
  endtask

  // flags = {adel, ri, syscall, break, ovf, ades}
  task automatic applyStimulus(input bit valid, input logic [5:0] flags, input logic [31:0] pc,
                               input bit bd, input bit eret, input bit occur, input logic [31:0] npc);
    bus.i_ev_valid   = valid;
    bus.i_ev_adel    = flags[5];
    bus.i_ev_ri      = flags[4];
    bus.i_ev_syscall = flags[3];
    bus.i_ev_break   = flags[2];
    bus.i_ev_ovf     = flags[1];
    bus.i_ev_ades    = flags[0];
    bus.i_ev_pc      = pc;
    bus.i_ev_bd      = bd;
    bus.i_ev_eret    = eret;
    bus.i_exc_occur  = occur;
    bus.i_exc_npc    = npc;
  endtask

  task automatic runException(input string name, input logic [5:0] flags, input logic [31:0] pc,
                              input bit bd, input bit eret, input bit preOccur,
                              input logic [3:0] code, input logic [31:0] epc, input logic [31:0] npc);
    outVec_t v;
    int base;
    tick();
    applyStimulus(1'b1, flags, pc, bd, eret, preOccur, npc);
    base = cyc;
    v = '0;
    v.code = code; v.epc = epc; v.bd = bd; v.stall = 1'b1;
    v.set = 1'b1;
    pushExp({name, "_set"}, base + 1, v, 1'b1);
    v.set = 1'b0;
    pushExp({name, "_wait"}, base + 2, v, 1'b1);
    v.flush = 1'b1;
    for (int k = 0; k < FC; k++) pushExp({name, "_flush"}, base + 3 + k, v, 1'b1);
    v.flush = 1'b0; v.ack = 1'b1; v.redirect = 1'b1; v.rpc = npc;
    pushExp({name, "_ack"}, base + 3 + FC, v, 1'b1);
    tick();
    applyStimulus(1'b0, 6'b0, pc, bd, 1'b0, preOccur, npc);
    tick();
    bus.i_exc_occur = 1'b1;
    repeat (FC + 1) tick();
    bus.i_exc_occur = 1'b0;
    tick();
  endtask

  task automatic runEret(input string name, input logic [31:0] npc);
    outVec_t v;
    int base;
    tick();
    applyStimulus(1'b1, 6'b0, 32'h0000_0300, 1'b0, 1'b1, 1'b0, npc);
    base = cyc;
    v = '0;
    v.stall = 1'b1; v.clr = 1'b1;
    pushExp({name, "_clr"}, base + 1, v, 1'b0);
    v.clr = 1'b0; v.redirect = 1'b1; v.rpc = npc; v.flush = 1'b1;
    pushExp({name, "_rdr"}, base + 2, v, 1'b0);
    tick();
    bus.i_ev_valid = 1'b0;
    bus.i_ev_eret  = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    outVec_t v;
    int base;
    applyStimulus(1'b0, 6'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    zeroChk = 1'b1;
    tick();
    zeroChk = 1'b0;
    rst = 1'b0;
    tick();

    runException("syscall", 6'b001000, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 4'd8,  32'h0000_0040, 32'h0000_0100);
    runException("ri_ovf",  6'b010010, 32'h0000_0084, 1'b1, 1'b0, 1'b0, 4'd10, 32'h0000_0080, 32'h0000_0100);
    runEret("eret", 32'h0000_0200);

    // Pending interrupt with no valid instruction: must stay idle.
    tick();
    applyStimulus(1'b0, 6'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0180);
    idleChk = 1'b1;
    repeat (3) tick();
    applyStimulus(1'b1, 6'b0, 32'h0000_0010, 1'b0, 1'b0, 1'b1, 32'h0000_0180);
    base = cyc;
    v = '0;
    v.epc = 32'h0000_0010; v.stall = 1'b1; v.flush = 1'b1;
    for (int k = 1; k <= FC; k++) pushExp("irq_flush", base + k, v, 1'b1);
    v.flush = 1'b0; v.ack = 1'b1; v.redirect = 1'b1; v.rpc = 32'h0000_0180;
    pushExp("irq_ack", base + 1 + FC, v, 1'b1);
    tick();
    idleChk = 1'b0;
    bus.i_ev_valid = 1'b0;
    repeat (FC) tick();
    bus.i_exc_occur = 1'b0;
    tick();

    runException("break_wrap", 6'b000100, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'd9,  32'hFFFF_FFFC, 32'h0000_0100);
    runException("adel_prio",  6'b100001, 32'h0000_1000, 1'b0, 1'b1, 1'b0, 4'd4,  32'h0000_1000, 32'h0000_0104);
    runException("ovf_irq",    6'b000010, 32'h0000_2000, 1'b0, 1'b0, 1'b1, 4'd12, 32'h0000_2000, 32'h0000_0108);
    runException("ades_bd",    6'b000001, 32'h0000_0024, 1'b1, 1'b0, 1'b0, 4'd5,  32'h0000_0020, 32'h0000_010C);

    // Flags without EV_VALID are not an event.
    tick();
    applyStimulus(1'b0, 6'b001000, 32'h0000_0050, 1'b0, 1'b1, 1'b0, 32'h0000_0100);
    idleChk = 1'b1;
    repeat (2) tick();
    idleChk = 1'b0;
    applyStimulus(1'b0, 6'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset in the middle of an interrupt flush.
    tick();
    applyStimulus(1'b1, 6'b0, 32'h0000_0030, 1'b0, 1'b0, 1'b1, 32'h0000_0180);
    base = cyc;
    v = '0;
    v.epc = 32'h0000_0030; v.stall = 1'b1; v.flush = 1'b1;
    pushExp("rst_flush", base + 1, v, 1'b1);
    tick();
    bus.i_ev_valid = 1'b0;
    tick();
    rst = 1'b1;
    zeroChk = 1'b1;
    tick();
    zeroChk = 1'b0;
    rst = 1'b0;
    bus.i_exc_occur = 1'b0;
    runEret("eret_after_rst", 32'h0000_0200);

    tick();
    endChk = 1'b1;
    tick();
    endChk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_exc_ctrl.md
# mips_exc_ctrl

Exception sequencer between the MipsCore commit stage and Coprocessor 0. It collects synchronous exception flags and ERET from the committing instruction, and also reacts to CP0-originated timer interrupts. For each event it runs the fixed handshake with CP0 (EXC_SET, then EXC_OCCUR, then EXC_ACK; or EXC_CLR for ERET), and it stalls, flushes and redirects the pipeline.

## Interface
- ADDR_W, 32, width of PC/EPC/NPC.
- FLUSH_CYCLES, 3, cycles FLUSH is held before ACK; legal range 1..15.

- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- EV_VALID  in  1  commit-stage instruction valid
- EV_PC  in  ADDR_W  commit-stage PC
- EV_BD  in  1  instruction sits in a branch delay slot
- EV_ADEL, EV_RI, EV_SYSCALL, EV_BREAK, EV_OVF, EV_ADES  in  1 each  exception flags
- EV_ERET  in  1  instruction is ERET
- EXC_OCCUR  in  1  CP0 exception pending
- EXC_NPC  in  ADDR_W  CP0 next PC (handler entry or EPC)
- EXC_SET  out  1  request to CP0
- EXC_CODE  out  4  cause code
- EXC_EPC  out  ADDR_W  return address
- EXC_BD  out  1  delay-slot flag
- EXC_ACK  out  1  exception taken
- EXC_CLR  out  1  ERET to CP0
- STALL  out  1  freeze the pipeline
- FLUSH  out  1  kill in-flight instructions
- REDIRECT  out  1  load REDIRECT_PC into the fetch PC
- REDIRECT_PC  out  ADDR_W  redirect target

## Operation
- All outputs are registered. On reset, every output is 0 and the state is IDLE.
- States: IDLE, SET, WAIT, FLUSH, ACK, CLR, RDR.
- IDLE with EV_VALID=1 and any exception flag set:
  - Priority and code: ADEL=4 > RI=10 > SYSCALL=8 > BREAK=9 > OVF=12 > ADES=5.
  - Latch EXC_CODE.
  - EXC_EPC = EV_BD ? EV_PC-4 (mod 2^ADDR_W) : EV_PC.
  - EXC_BD = EV_BD.
  - Go to SET.
- IDLE, no exception flag, EV_VALID=1, EV_ERET=1: go to CLR. Any exception flag wins over ERET.
- IDLE, no synchronous event, EXC_OCCUR=1 (interrupt):
  - If EV_VALID=1: latch EPC/BD from EV_PC/EV_BD exactly as above, EXC_CODE=0, go to FLUSH. EXC_SET is not asserted.
  - If EV_VALID=0: stay in IDLE with STALL=0 until a valid instruction reaches commit.
- A synchronous exception and EXC_OCCUR=1 in the same IDLE cycle take the SET path.
- SET: EXC_SET=1 for exactly one cycle, then go to WAIT.
- WAIT: leave when EXC_OCCUR=1 and go to FLUSH. There is no timeout.
- FLUSH: FLUSH=1 for FLUSH_CYCLES cycles (4-bit down-counter), then go to ACK.
- ACK: one cycle with EXC_ACK=1, REDIRECT=1 and REDIRECT_PC=EXC_NPC, then go to IDLE.
- CLR: one cycle with EXC_CLR=1, then go to RDR.
- RDR: one cycle with REDIRECT=1, REDIRECT_PC=EXC_NPC (now EPC) and FLUSH=1, then go to IDLE.
- STALL=1 in every state except IDLE. EV_* inputs are ignored outside IDLE.
- EXC_CODE, EXC_EPC and EXC_BD hold stable from latch until the ACK cycle completes.

## Timing
- Edge 0 is the IDLE edge that detects the exception. Cycle numbers below are counted after edge 0.
- Exception path:
  - SET occupies cycle 1, with EXC_SET=1.
  - CP0 raises EXC_OCCUR in cycle 2, so WAIT lasts exactly 1 cycle against a conforming CP0.
  - FLUSH occupies cycles 3..2+FLUSH_CYCLES.
  - ACK occupies cycle 3+FLUSH_CYCLES. This is cycle 6 at the default.
  - IDLE resumes in the cycle after ACK.
- Interrupt path: FLUSH starts in cycle 1, and ACK is in cycle 1+FLUSH_CYCLES.
- ERET path: EXC_CLR in cycle 1, REDIRECT in cycle 2 (after CP0 has registered EXC_NPC=EPC), IDLE in cycle 3.
- EXC_OCCUR is sampled only in WAIT and IDLE. Its level during FLUSH, ACK, CLR and RDR is ignored.
- RST asserted in any state forces IDLE and drives all outputs to 0 immediately.
  - A CP0 left with EXC_OCCUR=1 is treated as a pending interrupt on the next valid instruction.

## Test plan
- SYSCALL at EV_PC=0x0000_0040, EV_BD=0:
  - EXC_SET in cycle 1 with EXC_CODE=8, EXC_EPC=0x40, EXC_BD=0.
  - EXC_ACK and REDIRECT_PC=0x100 in cycle 6.
  - STALL high in cycles 1-6.
- RI together with OVF at EV_PC=0x0000_0084, EV_BD=1: EXC_CODE=10, EXC_EPC=0x80, EXC_BD=1.
- ERET with CP0 EPC=0x0000_0200: EXC_CLR in cycle 1, then REDIRECT=1 with REDIRECT_PC=0x200 and FLUSH=1 in cycle 2.
- EXC_OCCUR rises with EV_VALID=0 for 3 cycles, then EV_PC=0x0000_0010 is valid:
  - No STALL during the 3 idle cycles.
  - EXC_SET is never asserted.
  - EXC_EPC=0x10, and EXC_ACK comes FLUSH_CYCLES+1 cycles after detection.
- EV_BD=1, EV_PC=0x0000_0000 with BREAK: EXC_EPC=0xFFFF_FFFC (wrap), EXC_CODE=9.
- RST asserted during FLUSH: all outputs 0 the same cycle. After release, ERET is honoured normally from IDLE.
